icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter: IDX_W, 6, index width; cache holds 2^IDX_W one-word lines; index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].
REQ-002 clk  in  1  rising-edge clock; the block's only clock.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 if_e  in  1  fetch request from fetch stage.
REQ-005 if_a  in  32  fetch PC; word-aligned, low 2 bits ignored.
REQ-006 if_ok  out  1  one-cycle pulse; if_n valid.
REQ-007 if_n  out  32  fetched instruction word.
REQ-008 cache_hit  out  1  qualifies if_ok; 1 = served from array, 0 = served by refill.
REQ-009 mem_req  out  1  request for byte-serial memory port.
REQ-010 mem_gnt  in  1  port granted by memory controller; level, held while mem_req high.
REQ-011 mem_a  out  32  byte address to memory.
REQ-012 mem_rn  in  8  read byte; valid exactly one cycle after mem_a driven.
REQ-013 snp_e  in  1  data-side store strobe.
REQ-014 snp_a  in  32  store byte address.
REQ-015 flush  in  1  invalidate all lines.
REQ-016 abort  in  1  branch redirect; cancels the fetch in progress.

Function
REQ-017 States SHALL be IDLE, WAIT, FILL, DONE; reset state IDLE.
REQ-018 In IDLE with if_e=1 and abort=0, if_a SHALL be latched; requester holds if_e until if_ok.
REQ-019 Hit = valid[idx] and tag match, evaluated after same-cycle snoop/flush invalidation (REQ-027).
REQ-020 Hit in IDLE: next cycle if_ok=1, cache_hit=1, if_n=stored word; state stays IDLE; hit latency 1 cycle.
REQ-021 Miss in IDLE: next state WAIT, mem_req=1 from next cycle.
REQ-022 WAIT: on mem_gnt=1 go to FILL; mem_req held 1 through FILL.
REQ-023 FILL: mem_a SHALL be base, base+1, base+2, base+3 on consecutive cycles (base = if_a with [1:0]=0); bytes captured one cycle later, little-endian (first byte -> bits 7:0).
REQ-024 After fourth byte captured go to DONE; DONE lasts one cycle: line written (data, tag, valid=1), if_ok=1, cache_hit=0, mem_req=0, then IDLE.
REQ-025 Miss latency: if_ok SHALL assert 6 cycles after the first cycle mem_gnt is seen high in WAIT (4 address cycles, 1 trailing capture, DONE).
REQ-026 abort=1 in WAIT or FILL: return to IDLE next cycle, mem_req=0, no array write, no if_ok; abort in IDLE blocks acceptance that cycle; abort in DONE has no effect.
REQ-027 snp_e=1: valid[snp_a index] cleared if tag matches, any state; flush=1: all valid bits cleared next edge.
REQ-028 Snoop or flush matching the line being refilled (WAIT/FILL/DONE): word still delivered on if_ok, but line left invalid.
REQ-029 Snoop/flush and DONE write same cycle: invalidation wins.
REQ-030 if_ok, cache_hit SHALL be 0 except as above; if_n holds last value when if_ok=0.
REQ-031 mem_a SHALL be 0 when mem_req=0.
REQ-032 if_e in WAIT/FILL/DONE SHALL be ignored (no new latch).

Reset
REQ-033 rst=1 at any time, including mid-refill: state IDLE, all valid bits 0, if_ok=0, cache_hit=0, if_n=0, mem_req=0, mem_a=0, byte counter 0; array data/tags need not reset.
REQ-034 First request after reset SHALL miss.

Verification
REQ-035 Cold fetch if_a=0x1000, gnt immediate, bytes 13,00,00,00 -> if_ok with if_n=0x00000013, cache_hit=0, mem_a sequence 0x1000..0x1003.
REQ-036 Refetch 0x1000 -> if_ok next cycle, cache_hit=1, if_n=0x00000013, mem_req stays 0.
REQ-037 Fetch 0x1100 (same index, IDX_W=6) then 0x1000 -> both miss; 0x1000 refilled.
REQ-038 Store snp_a=0x1002 then fetch 0x1000 -> miss; flush then fetch 0x1100 -> miss.
REQ-039 abort during FILL second byte -> IDLE next cycle, no if_ok, refetch misses.
REQ-040 rst asserted during FILL -> all outputs 0 immediately, next fetch misses.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line, refilled over a
// byte-serial memory port; data-side store snooping and full flush.
module icache_dm #(
   parameter int unsigned IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_e,
   input  logic [31:0] if_a,
   output logic        if_ok,
   output logic [31:0] if_n,
   output logic        cache_hit,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [31:0] mem_a,
   input  logic [7:0]  mem_rn,
   input  logic        snp_e,
   input  logic [31:0] snp_a,
   input  logic        flush,
   input  logic        abort
);

   localparam int unsigned LINES = 1 << IDX_W;
   localparam int unsigned TAG_W = 30 - IDX_W;

   typedef enum logic [1:0] {IDLE, WAIT, FILL, DONE} state_t;

   state_t            state, state_nx;
   logic [31:2]       req_a;
   logic [2:0]        cnt;
   logic [31:0]       fill;
   logic              inv_pend;
   logic [LINES-1:0]  valid;
   logic [31:0]       data_arr [LINES];
   logic [TAG_W-1:0]  tag_arr  [LINES];

   logic [IDX_W-1:0]  if_idx, snp_idx, req_idx;
   logic [TAG_W-1:0]  if_tag, snp_tag, req_tag;
   logic              lookup_hit, kill_now, accept;
   logic [1:0]        byte_sel;
   logic              unused_bits;

   assign if_idx  = if_a[IDX_W+1:2];
   assign if_tag  = if_a[31:IDX_W+2];
   assign snp_idx = snp_a[IDX_W+1:2];
   assign snp_tag = snp_a[31:IDX_W+2];
   assign req_idx = req_a[IDX_W+1:2];
   assign req_tag = req_a[31:IDX_W+2];
   assign unused_bits = ^{if_a[1:0], snp_a[1:0]};

   // Lookup sees this cycle's snoop/flush as already applied.
   assign lookup_hit = valid[if_idx] && (tag_arr[if_idx] == if_tag) && !flush &&
                       !(snp_e && (snp_idx == if_idx) && (snp_tag == if_tag));
   assign kill_now   = flush || (snp_e && (snp_idx == req_idx) && (snp_tag == req_tag));
   // cnt 1..4 captures bytes 0..3
   assign byte_sel   = cnt[1:0] - 2'd1;

   always_comb begin
      mem_req = (state == WAIT) || (state == FILL);
      mem_a   = mem_req ? {req_a, cnt[1:0]} : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            // if_ok high means the requester is still dropping if_e for the word just delivered
            if (if_e && !abort && !if_ok) begin
               accept = 1'b1;
               if (!lookup_hit) state_nx = WAIT;
            end
         end
         WAIT: begin
            if (abort)        state_nx = IDLE;
            else if (mem_gnt) state_nx = FILL;
         end
         FILL: begin
            if (abort)              state_nx = IDLE;
            else if (cnt == 3'd4)   state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_a     <= '0;
         cnt       <= '0;
         fill      <= '0;
         inv_pend  <= 1'b0;
         if_ok     <= 1'b0;
         cache_hit <= 1'b0;
         if_n      <= '0;
      end else begin
         if_ok     <= 1'b0;
         cache_hit <= 1'b0;
         if (state != IDLE && kill_now) inv_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  req_a    <= if_a[31:2];
                  inv_pend <= 1'b0;
                  if (lookup_hit) begin
                     if_ok     <= 1'b1;
                     cache_hit <= 1'b1;
                     if_n      <= data_arr[if_idx];
                  end
               end
            end
            FILL: begin
               if (abort) begin
                  cnt <= '0;
               end else begin
                  if (cnt != 3'd0) fill[{byte_sel, 3'b000} +: 8] <= mem_rn;
                  if (cnt == 3'd4) begin
                     cnt   <= '0;
                     if_ok <= 1'b1;
                     if_n  <= {mem_rn, fill[23:0]};
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == DONE) begin
         data_arr[req_idx] <= fill;
         tag_arr[req_idx]  <= req_tag;
      end
   end

   // The DONE write comes last so a same-cycle or earlier kill of the refilling line wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else begin
         if (flush) valid <= '0;
         else if (snp_e && (tag_arr[snp_idx] == snp_tag)) valid[snp_idx] <= 1'b0;
         if (state == DONE) valid[req_idx] <= !(inv_pend || kill_now);
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold/warm fetches, conflicts, snoop, flush,
// abort, grant delay and reset during refill, against a byte-serial memory model.
module tb_icache_dm;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_e;
   logic [31:0] if_a;
   logic        if_ok;
   logic [31:0] if_n;
   logic        cache_hit;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_a;
   logic [7:0]  mem_rn;
   logic        snp_e;
   logic [31:0] snp_a;
   logic        flush;
   logic        abort;
   logic        gnt_ok;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   icache_dm #(.IDX_W(6)) dut (
      .clk(clk), .rst(rst), .if_e(if_e), .if_a(if_a), .if_ok(if_ok), .if_n(if_n),
      .cache_hit(cache_hit), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_a(mem_a),
      .mem_rn(mem_rn), .snp_e(snp_e), .snp_a(snp_a), .flush(flush), .abort(abort)
   );

   // Memory image: word 0x1000 holds 0x00000013, every other byte is addr[7:0]+0x21.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (a[31:2] == 30'h400) return (a[1:0] == 2'd0) ? 8'h13 : 8'h00;
      return a[7:0] + 8'h21;
   endfunction

   assign mem_gnt = mem_req & gnt_ok;

   always @(posedge clk) mem_rn <= mem_req ? mem_byte(mem_a) : 8'h00;

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", nm, obs, exp);
      end
   endtask

   // d = grant delay in cycles; snp_k > 0 pulses a matching snoop at that step.
   task automatic fetch(input logic [31:0] a, input logic [31:0] w, input logic exp_hit,
                        input int d, input int snp_k, input string nm);
      logic [31:0] ma [16];
      logic        seen = 1'b0;
      logic        req_seen = 1'b0;
      logic        bad_mema = 1'b0;
      logic [31:0] got_n = '0;
      logic        got_hit = 1'b0;
      int          lat = 0;
      for (int i = 0; i < 16; i++) ma[i] = '0;
      @(negedge clk);
      if_e = 1'b1; if_a = a; gnt_ok = 1'b0;
      for (int k = 1; k <= 40 + d && !seen; k++) begin
         @(negedge clk);
         if (k < 16) ma[k] = mem_a;
         if (mem_req) req_seen = 1'b1;
         if (!mem_req && mem_a != 32'h0) bad_mema = 1'b1;
         if (if_ok) begin
            seen = 1'b1; lat = k; got_n = if_n; got_hit = cache_hit; if_e = 1'b0;
         end
         gnt_ok = (k >= 1 + d);
         if (k == snp_k) begin snp_e = 1'b1; snp_a = a | 32'h2; end
         else snp_e = 1'b0;
      end
      if_e = 1'b0; gnt_ok = 1'b0; snp_e = 1'b0;
      chk({nm, "_seen"}, {31'b0, seen}, 32'd1);
      chk({nm, "_lat"}, lat, exp_hit ? 32'd1 : 32'(7 + d));
      chk({nm, "_data"}, got_n, w);
      chk({nm, "_hit"}, {31'b0, got_hit}, {31'b0, exp_hit});
      chk({nm, "_mema_idle"}, {31'b0, bad_mema}, 32'd0);
      if (exp_hit) begin
         chk({nm, "_noreq"}, {31'b0, req_seen}, 32'd0);
      end else begin
         for (int i = 0; i < 4; i++) chk({nm, "_mema"}, ma[2 + d + i], a + 32'(i));
      end
      @(negedge clk);
      chk({nm, "_pulse"}, {31'b0, if_ok}, 32'd0);
      chk({nm, "_hold"}, if_n, w);
   endtask

   initial begin
      logic ok_seen;
      rst = 1'b0; if_e = 1'b0; if_a = '0; snp_e = 1'b0; snp_a = '0;
      flush = 1'b0; abort = 1'b0; gnt_ok = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("rst_ok", {31'b0, if_ok}, 32'd0);
      chk("rst_hit", {31'b0, cache_hit}, 32'd0);
      chk("rst_n", if_n, 32'h0);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mema", mem_a, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      fetch(32'h1000, 32'h0000_0013, 1'b0, 0, 0, "cold");
      fetch(32'h1000, 32'h0000_0013, 1'b1, 0, 0, "warm");
      fetch(32'h1100, 32'h2423_2221, 1'b0, 0, 0, "conflict");
      fetch(32'h1000, 32'h0000_0013, 1'b0, 0, 0, "evicted");
      fetch(32'h1000, 32'h0000_0013, 1'b1, 0, 0, "rewarm");

      // Store to a different tag on the same index leaves the line alone.
      @(negedge clk); snp_e = 1'b1; snp_a = 32'h1100;
      @(negedge clk); snp_e = 1'b0;
      fetch(32'h1000, 32'h0000_0013, 1'b1, 0, 0, "snp_other");

      @(negedge clk); snp_e = 1'b1; snp_a = 32'h1002;
      @(negedge clk); snp_e = 1'b0;
      fetch(32'h1000, 32'h0000_0013, 1'b0, 0, 0, "snp_hit");

      fetch(32'h1100, 32'h2423_2221, 1'b0, 3, 0, "gnt_dly");
      fetch(32'h1100, 32'h2423_2221, 1'b1, 0, 0, "pre_flush");
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      fetch(32'h1100, 32'h2423_2221, 1'b0, 0, 0, "flushed");

      // Abort while the second byte address is on the port.
      @(negedge clk); if_e = 1'b1; if_a = 32'h2040; gnt_ok = 1'b0;
      @(negedge clk); gnt_ok = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("abort_mema", mem_a, 32'h2041);
      abort = 1'b1; if_e = 1'b0;
      @(negedge clk);
      abort = 1'b0; gnt_ok = 1'b0;
      chk("abort_req", {31'b0, mem_req}, 32'd0);
      chk("abort_mema0", mem_a, 32'h0);
      ok_seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (if_ok) ok_seen = 1'b1;
      end
      chk("abort_no_ok", {31'b0, ok_seen}, 32'd0);
      fetch(32'h2040, 32'h6463_6261, 1'b0, 0, 0, "abort_re");
      fetch(32'h2040, 32'h6463_6261, 1'b1, 0, 0, "abort_warm");

      fetch(32'h2080, 32'hA4A3_A2A1, 1'b0, 0, 3, "snp_fill");
      fetch(32'h2080, 32'hA4A3_A2A1, 1'b0, 0, 0, "snp_fill_re");

      // Reset in the middle of a refill.
      @(negedge clk); if_e = 1'b1; if_a = 32'h3000; gnt_ok = 1'b0;
      @(negedge clk); gnt_ok = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ok", {31'b0, if_ok}, 32'd0);
      chk("mid_rst_hit", {31'b0, cache_hit}, 32'd0);
      chk("mid_rst_n", if_n, 32'h0);
      chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
      chk("mid_rst_mema", mem_a, 32'h0);
      @(negedge clk);
      rst = 1'b0; if_e = 1'b0; gnt_ok = 1'b0;
      fetch(32'h2040, 32'h6463_6261, 1'b0, 0, 0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
